// File: rtl/decoder_pipe.sv
// decoder_pipe: two-stage single-error-correcting syndrome decoder with
// valid/ready handshakes on both sides and saturating error counters.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cx, in_valid,         received codeword (parity in [R-1:0], data above),
//   in_ready, correct_en  input handshake, correct (1) / detect-only (0)
//   d, out_valid,         decoded data and output handshake
//   out_ready
//   err_det, err_corr,    nonzero syndrome / single error corrected /
//   err_uncorr, err_pos   nonzero syndrome matching no column / fixed bit index
//   clear_cnt             synchronous clear of both counters
//   cnt_corr, cnt_uncorr  saturating counts of corrected / uncorrectable words
module decoder_pipe #(
  parameter int N = 19,
  parameter int K = 8,
  parameter logic [K*(N-K)-1:0] P_COLS = {11'h329, 11'h211, 11'h443, 11'h631,
                                          11'h5CF, 11'h4E2, 11'h335, 11'h5B4},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     cx,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             correct_en,
  output logic [K-1:0]     d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_det,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [4:0]       err_pos,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  localparam int R = N - K;
  localparam logic [R-1:0] ONE_R = {{(R-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  // Column j of H = [I_R | P].
  function automatic logic [R-1:0] f_col(input int unsigned j);
    logic [K*R-1:0] w_p;
    w_p = P_COLS >> (R * (j - R));
    if (j < R) return ONE_R << j;
    return w_p[R-1:0];
  endfunction

  function automatic logic [R-1:0] f_syn(input logic [N-1:0] c);
    logic [R-1:0] w_s;
    w_s = '0;
    for (int unsigned j = 0; j < N; j++)
      if (c[j]) w_s = w_s ^ f_col(j);
    return w_s;
  endfunction

  // Stage 1
  logic           r_v1;
  logic           r_ce1;
  logic [N-1:0]   r_cx1;
  logic [R-1:0]   r_s1;
  // Stage 2 (output registers)
  logic           r_v2;
  logic [K-1:0]   r_d;
  logic           r_det;
  logic           r_corr;
  logic           r_unc;
  logic [4:0]     r_pos;
  logic [CNT_W-1:0] r_cnt_c;
  logic [CNT_W-1:0] r_cnt_u;

  logic           w_out_fire;
  logic           w_ld2;
  logic           w_in_fire;
  logic           w_hit;
  logic [4:0]     w_pos;
  logic           w_det;
  logic           w_corr;
  logic           w_unc;
  logic [N-1:0]   w_fixed;

  assign w_out_fire = r_v2 & out_ready;
  assign w_ld2      = r_v1 & (~r_v2 | out_ready);
  assign in_ready   = ~r_v1 | w_ld2;
  assign w_in_fire  = in_valid & in_ready;

  // The syndrome of the incoming word is captured together with it, so r_s1
  // is always the syndrome of r_cx1 and stage 2 only has to match it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1  <= 1'b0;
      r_ce1 <= 1'b0;
      r_cx1 <= '0;
      r_s1  <= '0;
    end else if (w_in_fire) begin
      r_v1  <= 1'b1;
      r_ce1 <= correct_en;
      r_cx1 <= cx;
      r_s1  <= f_syn(cx);
    end else if (w_ld2) begin
      r_v1  <= 1'b0;
    end
  end

  // Descending scan so that the lowest matching column is the one kept.
  always_comb begin
    w_hit = 1'b0;
    w_pos = '0;
    for (int unsigned j = N; j > 0; j--) begin
      if (r_s1 == f_col(j - 1)) begin
        w_hit = 1'b1;
        w_pos = 5'(j - 1);
      end
    end
  end

  assign w_det   = |r_s1;
  assign w_corr  = w_det & r_ce1 & w_hit;
  assign w_unc   = w_det & r_ce1 & ~w_hit;
  assign w_fixed = r_cx1 ^ (w_corr ? (ONE_N << w_pos) : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2   <= 1'b0;
      r_d    <= '0;
      r_det  <= 1'b0;
      r_corr <= 1'b0;
      r_unc  <= 1'b0;
      r_pos  <= '0;
    end else if (w_ld2) begin
      r_v2   <= 1'b1;
      r_d    <= w_fixed[N-1:R];
      r_det  <= w_det;
      r_corr <= w_corr;
      r_unc  <= w_unc;
      r_pos  <= w_corr ? w_pos : '0;
    end else if (w_out_fire) begin
      r_v2   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_c <= '0;
      r_cnt_u <= '0;
    end else if (clear_cnt) begin
      r_cnt_c <= '0;
      r_cnt_u <= '0;
    end else begin
      if (w_out_fire && r_corr && !(&r_cnt_c)) r_cnt_c <= r_cnt_c + CNT_W'(1);
      if (w_out_fire && r_unc && !(&r_cnt_u))  r_cnt_u <= r_cnt_u + CNT_W'(1);
    end
  end

  assign out_valid  = r_v2;
  assign d          = r_d;
  assign err_det    = r_det;
  assign err_corr   = r_corr;
  assign err_uncorr = r_unc;
  assign err_pos    = r_pos;
  assign cnt_corr   = r_cnt_c;
  assign cnt_uncorr = r_cnt_u;

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

  localparam int N  = 19;
  localparam int K  = 8;
  localparam int R  = 11;
  localparam int CW = 3;
  localparam logic [87:0] PC = {11'h329, 11'h211, 11'h443, 11'h631,
                                11'h5CF, 11'h4E2, 11'h335, 11'h5B4};
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk;
  logic          reset;
  logic [N-1:0]  cx;
  logic          in_valid;
  logic          in_ready;
  logic          correct_en;
  logic [K-1:0]  d;
  logic          out_valid;
  logic          out_ready;
  logic          err_det;
  logic          err_corr;
  logic          err_uncorr;
  logic [4:0]    err_pos;
  logic          clear_cnt;
  logic [CW-1:0] cnt_corr;
  logic [CW-1:0] cnt_uncorr;

  decoder_pipe #(.N(N), .K(K), .P_COLS(PC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cx(cx), .in_valid(in_valid), .in_ready(in_ready),
    .correct_en(correct_en), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .err_det(err_det), .err_corr(err_corr), .err_uncorr(err_uncorr),
    .err_pos(err_pos), .clear_cnt(clear_cnt), .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_cc     = 0;
  int m_cu     = 0;
  logic [N:0] src_q[$];

  typedef struct packed {
    logic [7:0] d;
    logic       det;
    logic       corr;
    logic       unc;
    logic [4:0] pos;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: H built from the parity definition, decoding by trying
  // every single-bit flip and keeping the first that yields a zero syndrome.
  function automatic logic [R-1:0] hcol(input int unsigned j);
    logic [87:0] p;
    p = PC >> (R * (j - R));
    if (j < R) return 11'(1) << j;
    return p[10:0];
  endfunction

  function automatic logic [R-1:0] ref_syn(input logic [N-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int unsigned j = 0; j < N; j++)
      if (c[j]) s = s ^ hcol(j);
    return s;
  endfunction

  function automatic exp_t ref_dec(input logic [N-1:0] c, input logic ce);
    exp_t e;
    logic [N-1:0] f;
    e.d = c[18:11]; e.det = |ref_syn(c); e.corr = 1'b0; e.unc = 1'b0; e.pos = '0;
    if (e.det && ce) begin
      for (int unsigned j = 0; j < N; j++) begin
        f = c ^ (19'(1) << j);
        if (!e.corr && ref_syn(f) == '0) begin
          e.corr = 1'b1; e.pos = 5'(j); e.d = f[18:11];
        end
      end
      e.unc = ~e.corr;
    end
    return e;
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [7:0]   dat;
    logic [R-1:0] par;
    logic [N-1:0] w;
    dat = 8'($urandom);
    par = '0;
    for (int unsigned k = 0; k < K; k++)
      if (dat[k]) par = par ^ hcol(R + k);
    w = {dat, par};
    repeat ($urandom_range(0, 2)) w = w ^ (19'(1) << $urandom_range(0, N - 1));
    return w;
  endfunction

  task automatic count(input logic corr, input logic unc, input logic clr);
    if (clr) begin m_cc = 0; m_cu = 0; end
    else begin
      if (corr && m_cc < int'(CMAX)) m_cc++;
      if (unc && m_cu < int'(CMAX)) m_cu++;
    end
  endtask

  function automatic logic [15:0] obs_out();
    return {d, err_det, err_corr, err_uncorr, err_pos};
  endfunction

  task automatic one_word(input string tag, input logic [N-1:0] c, input logic ce,
                          input logic clr, input logic [7:0] ed, input logic edet,
                          input logic ecorr, input logic eunc, input logic [4:0] epos);
    @(negedge clk);
    cx = c; correct_en = ce; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".d"}, d, ed);
    chk({tag, ".det"}, err_det, edet);
    chk({tag, ".corr"}, err_corr, ecorr);
    chk({tag, ".unc"}, err_uncorr, eunc);
    chk({tag, ".pos"}, err_pos, epos);
    chk({tag, ".model"}, obs_out(), ref_dec(c, ce));
    clear_cnt = clr;
    count(ecorr, eunc, clr);
    @(negedge clk);
    clear_cnt = 1'b0;
    chk({tag, ".cnt_corr"}, cnt_corr, m_cc);
    chk({tag, ".cnt_uncorr"}, cnt_uncorr, m_cu);
    chk({tag, ".drained"}, out_valid, 0);
  endtask

  // mode 0: in_valid held, out_ready low for the first 3 cycles; mode 1: random.
  task automatic run_stream(input string tag, input int mode, input int budget);
    exp_t sb[$];
    exp_t e;
    logic pend_hold;
    logic [15:0] held;
    int cyc;
    pend_hold = 1'b0; held = '0; cyc = 0;
    while ((src_q.size() > 0 || sb.size() > 0) && cyc < budget) begin
      @(negedge clk);
      in_valid = (src_q.size() > 0) && (mode == 0 || $urandom_range(0, 3) != 0);
      if (src_q.size() > 0) {correct_en, cx} = src_q[0];
      out_ready = (mode == 0) ? (cyc >= 3) : ($urandom_range(0, 2) != 0);
      #1;
      chk({tag, ".in_ready"}, in_ready, (sb.size() < 2) || out_ready);
      if (pend_hold) chk({tag, ".hold"}, {out_valid, obs_out()}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk({tag, ".dup"}, 1, 0);
        else begin
          e = sb.pop_front();
          chk({tag, ".order"}, obs_out(), e);
          count(e.corr, e.unc, 1'b0);
        end
      end
      pend_hold = out_valid && !out_ready;
      held = obs_out();
      if (in_valid && in_ready) begin
        sb.push_back(ref_dec(src_q[0][N-1:0], src_q[0][N]));
        void'(src_q.pop_front());
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".drain"}, sb.size() + src_q.size(), 0);
    chk({tag, ".cnt_corr"}, cnt_corr, m_cc);
    chk({tag, ".cnt_uncorr"}, cnt_uncorr, m_cu);
    src_q.delete();
  endtask

  initial begin
    reset = 1'b1; cx = '0; in_valid = 1'b0; correct_en = 1'b1;
    out_ready = 1'b1; clear_cnt = 1'b0;
    #12;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out", obs_out(), 0);
    chk("rst.cnt", {cnt_corr, cnt_uncorr}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst.in_ready", in_ready, 1);

    one_word("zero",   19'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
    one_word("b11",    19'h005B4, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 5'd11);
    one_word("b3",     19'h00008, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd3);
    one_word("b3det",  19'h00008, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0);
    one_word("double", 19'h00003, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0);
    one_word("clrwin", 19'h00008, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 5'd3);

    src_q.push_back({1'b1, 19'h005B4});
    src_q.push_back({1'b1, 19'h00003});
    src_q.push_back({1'b0, 19'h00008});
    src_q.push_back({1'b1, rand_word()});
    run_stream("stall", 0, 40);

    for (int i = 0; i < 200; i++) src_q.push_back({1'($urandom), rand_word()});
    run_stream("rand", 1, 2000);

    // Reset with two words in flight.
    @(negedge clk);
    cx = 19'h005B4; correct_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    cx = 19'h00003;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.out_valid_pre", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid.out_valid", out_valid, 0);
    chk("mid.cnt", {cnt_corr, cnt_uncorr}, 0);
    chk("mid.out", obs_out(), 0);
    m_cc = 0; m_cu = 0;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("mid.in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("mid.flushed", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
